// File: rtl/rggen_axi4lite_request_slice_if.sv
// AXI4-Lite bundle shared by both sides of the request slice.
interface rggen_axi4lite_if #(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned BUS_WIDTH     = 32
);
  localparam int unsigned STRB_WIDTH = BUS_WIDTH / 8;

  logic                     awvalid;
  logic                     awready;
  logic [ADDRESS_WIDTH-1:0] awaddr;
  logic [2:0]               awprot;
  logic                     wvalid;
  logic                     wready;
  logic [BUS_WIDTH-1:0]     wdata;
  logic [STRB_WIDTH-1:0]    wstrb;
  logic                     bvalid;
  logic                     bready;
  logic [1:0]               bresp;
  logic                     arvalid;
  logic                     arready;
  logic [ADDRESS_WIDTH-1:0] araddr;
  logic [2:0]               arprot;
  logic                     rvalid;
  logic                     rready;
  logic [BUS_WIDTH-1:0]     rdata;
  logic [1:0]               rresp;

  modport master (
    output awvalid, awaddr, awprot,
    input  awready,
    output wvalid, wdata, wstrb,
    input  wready,
    input  bvalid, bresp,
    output bready,
    output arvalid, araddr, arprot,
    input  arready,
    input  rvalid, rdata, rresp,
    output rready
  );

  modport slave (
    input  awvalid, awaddr, awprot,
    output awready,
    input  wvalid, wdata, wstrb,
    output wready,
    output bvalid, bresp,
    input  bready,
    input  arvalid, araddr, arprot,
    output arready,
    output rvalid, rdata, rresp,
    input  rready
  );
endinterface

// File: rtl/rggen_axi4lite_request_slice.sv
// Registered AXI4-Lite slice: 2-entry skid buffer on AW, W and AR.
// Define RGGEN_AXI4LITE_RESPONSE_SLICE_EN to also slice B and R; otherwise they pass through.

// One 2-entry skid buffer; handshake outputs come straight from the state flops.
module rggen_axi4lite_request_slice_stage #(
  parameter int unsigned WIDTH = 1
)(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_s_valid,
  output logic             o_s_ready,
  input  logic [WIDTH-1:0] i_s_payload,
  output logic             o_m_valid,
  input  logic             i_m_ready,
  output logic [WIDTH-1:0] o_m_payload
);
  // Encoding puts m_valid in bit 1 and s_ready in bit 0.
  typedef enum logic [1:0] {
    EMPTY = 2'b01,
    ONE   = 2'b11,
    FULL  = 2'b10
  } state_e;

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] skid_d;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Payload storage carries no reset; validity lives only in the state.
  always_ff @(posedge i_clk) begin
    main_q <= main_d;
    skid_q <= skid_d;
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (i_s_valid) begin
          main_d  = i_s_payload;
          state_d = ONE;
        end
      end
      ONE: begin
        if (i_s_valid && i_m_ready) begin
          main_d = i_s_payload;
        end else if (i_s_valid) begin
          skid_d  = i_s_payload;
          state_d = FULL;
        end else if (i_m_ready) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (i_m_ready) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  assign o_s_ready   = state_q[0];
  assign o_m_valid   = state_q[1];
  assign o_m_payload = main_q;
endmodule

module rggen_axi4lite_request_slice #(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned BUS_WIDTH     = 32
)(
  input logic             i_clk,
  input logic             i_rst_n,
  rggen_axi4lite_if.slave  slave_if,
  rggen_axi4lite_if.master master_if
);
  localparam int unsigned STRB_WIDTH = BUS_WIDTH / 8;
  localparam int unsigned AX_WIDTH   = ADDRESS_WIDTH + 3;
  localparam int unsigned W_WIDTH    = BUS_WIDTH + STRB_WIDTH;

  logic [AX_WIDTH-1:0] aw_s_payload;
  logic [AX_WIDTH-1:0] aw_m_payload;
  logic [W_WIDTH-1:0]  w_s_payload;
  logic [W_WIDTH-1:0]  w_m_payload;
  logic [AX_WIDTH-1:0] ar_s_payload;
  logic [AX_WIDTH-1:0] ar_m_payload;

  assign aw_s_payload = {slave_if.awprot, slave_if.awaddr};
  assign w_s_payload  = {slave_if.wstrb, slave_if.wdata};
  assign ar_s_payload = {slave_if.arprot, slave_if.araddr};

  rggen_axi4lite_request_slice_stage #(.WIDTH(AX_WIDTH)) u_aw_slice (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_s_valid   (slave_if.awvalid),
    .o_s_ready   (slave_if.awready),
    .i_s_payload (aw_s_payload),
    .o_m_valid   (master_if.awvalid),
    .i_m_ready   (master_if.awready),
    .o_m_payload (aw_m_payload)
  );

  rggen_axi4lite_request_slice_stage #(.WIDTH(W_WIDTH)) u_w_slice (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_s_valid   (slave_if.wvalid),
    .o_s_ready   (slave_if.wready),
    .i_s_payload (w_s_payload),
    .o_m_valid   (master_if.wvalid),
    .i_m_ready   (master_if.wready),
    .o_m_payload (w_m_payload)
  );

  rggen_axi4lite_request_slice_stage #(.WIDTH(AX_WIDTH)) u_ar_slice (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_s_valid   (slave_if.arvalid),
    .o_s_ready   (slave_if.arready),
    .i_s_payload (ar_s_payload),
    .o_m_valid   (master_if.arvalid),
    .i_m_ready   (master_if.arready),
    .o_m_payload (ar_m_payload)
  );

  assign master_if.awaddr = aw_m_payload[ADDRESS_WIDTH-1:0];
  assign master_if.awprot = aw_m_payload[AX_WIDTH-1:ADDRESS_WIDTH];
  assign master_if.wdata  = w_m_payload[BUS_WIDTH-1:0];
  assign master_if.wstrb  = w_m_payload[W_WIDTH-1:BUS_WIDTH];
  assign master_if.araddr = ar_m_payload[ADDRESS_WIDTH-1:0];
  assign master_if.arprot = ar_m_payload[AX_WIDTH-1:ADDRESS_WIDTH];

`ifdef RGGEN_AXI4LITE_RESPONSE_SLICE_EN
  localparam int unsigned R_WIDTH = BUS_WIDTH + 2;

  logic [R_WIDTH-1:0] r_s_payload;
  logic [R_WIDTH-1:0] r_m_payload;

  assign r_s_payload = {master_if.rresp, master_if.rdata};

  // Responses flow from the adapter back toward the upstream master.
  rggen_axi4lite_request_slice_stage #(.WIDTH(2)) u_b_slice (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_s_valid   (master_if.bvalid),
    .o_s_ready   (master_if.bready),
    .i_s_payload (master_if.bresp),
    .o_m_valid   (slave_if.bvalid),
    .i_m_ready   (slave_if.bready),
    .o_m_payload (slave_if.bresp)
  );

  rggen_axi4lite_request_slice_stage #(.WIDTH(R_WIDTH)) u_r_slice (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_s_valid   (master_if.rvalid),
    .o_s_ready   (master_if.rready),
    .i_s_payload (r_s_payload),
    .o_m_valid   (slave_if.rvalid),
    .i_m_ready   (slave_if.rready),
    .o_m_payload (r_m_payload)
  );

  assign slave_if.rdata = r_m_payload[BUS_WIDTH-1:0];
  assign slave_if.rresp = r_m_payload[R_WIDTH-1:BUS_WIDTH];
`else
  assign slave_if.bvalid  = master_if.bvalid;
  assign slave_if.bresp   = master_if.bresp;
  assign master_if.bready = slave_if.bready;
  assign slave_if.rvalid  = master_if.rvalid;
  assign slave_if.rdata   = master_if.rdata;
  assign slave_if.rresp   = master_if.rresp;
  assign master_if.rready = slave_if.rready;
`endif
endmodule

// File: tb/tb_rggen_axi4lite_request_slice.sv
// Bench for rggen_axi4lite_request_slice: directed scenarios plus a random stream,
// with per-channel scoreboards keyed on handshakes at both sides.
module tb_rggen_axi4lite_request_slice;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
`ifdef RGGEN_AXI4LITE_RESPONSE_SLICE_EN
  localparam logic RESP_SLICE = 1'b1;
`else
  localparam logic RESP_SLICE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rggen_axi4lite_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(DW)) up_if ();
  rggen_axi4lite_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(DW)) dn_if ();

  rggen_axi4lite_request_slice #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(DW)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .slave_if  (up_if.slave),
    .master_if (dn_if.master)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] sbq  [5][$];
  logic        hold [5];
  logic [63:0] held [5];

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Push on input-side accept, check stability while stalled, pop on output-side accept.
  task automatic sb_step(input int unsigned ch, input string nm, input logic in_hs,
                         input logic [63:0] in_pl, input logic out_v, input logic out_rdy,
                         input logic [63:0] out_pl);
    if (in_hs) sbq[ch].push_back(in_pl);
    if (hold[ch]) begin
      check_eq({nm, "_held_valid"}, 64'(out_v), 64'd1);
      check_eq({nm, "_held_data"}, out_pl, held[ch]);
    end
    if (out_v && out_rdy) begin
      if (sbq[ch].size() == 0) check_eq({nm, "_queued"}, 64'(sbq[ch].size()), 64'd1);
      else check_eq({nm, "_data"}, out_pl, sbq[ch].pop_front());
    end
    hold[ch] = out_v && !out_rdy;
    held[ch] = out_pl;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) begin
        sbq[i].delete();
        hold[i] = 1'b0;
      end
    end else begin
      sb_step(0, "aw", up_if.awvalid && up_if.awready, 64'({up_if.awprot, up_if.awaddr}),
              dn_if.awvalid, dn_if.awready, 64'({dn_if.awprot, dn_if.awaddr}));
      sb_step(1, "w", up_if.wvalid && up_if.wready, 64'({up_if.wstrb, up_if.wdata}),
              dn_if.wvalid, dn_if.wready, 64'({dn_if.wstrb, dn_if.wdata}));
      sb_step(2, "ar", up_if.arvalid && up_if.arready, 64'({up_if.arprot, up_if.araddr}),
              dn_if.arvalid, dn_if.arready, 64'({dn_if.arprot, dn_if.araddr}));
      sb_step(3, "b", dn_if.bvalid && dn_if.bready, 64'(dn_if.bresp),
              up_if.bvalid, up_if.bready, 64'(up_if.bresp));
      sb_step(4, "r", dn_if.rvalid && dn_if.rready, 64'({dn_if.rresp, dn_if.rdata}),
              up_if.rvalid, up_if.rready, 64'({up_if.rresp, up_if.rdata}));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 5; i++) begin
      hold[i] = 1'b0;
      held[i] = '0;
    end
    rst_n = 1'b0;
    up_if.awvalid = 1'b1; up_if.awaddr = 8'h55; up_if.awprot = 3'd0;
    up_if.wvalid  = 1'b0; up_if.wdata  = '0;    up_if.wstrb  = '0;
    up_if.arvalid = 1'b0; up_if.araddr = '0;    up_if.arprot = 3'd0;
    up_if.bready  = 1'b0; up_if.rready = 1'b0;
    dn_if.awready = 1'b0; dn_if.wready = 1'b0; dn_if.arready = 1'b0;
    dn_if.bvalid  = 1'b0; dn_if.bresp  = 2'b10;
    dn_if.rvalid  = 1'b0; dn_if.rdata  = '0;   dn_if.rresp   = 2'b10;

    // T1 reset with upstream awvalid asserted
    tick(); at_neg();
    check_eq("t1_awvalid_rst", 64'(dn_if.awvalid), 64'd0);
    check_eq("t1_wvalid_rst",  64'(dn_if.wvalid),  64'd0);
    check_eq("t1_arvalid_rst", 64'(dn_if.arvalid), 64'd0);
    tick(); rst_n = 1'b1; up_if.awvalid = 1'b0; at_neg();
    check_eq("t1_awvalid_rst2", 64'(dn_if.awvalid), 64'd0);
    check_eq("t1_awready", 64'(up_if.awready), 64'd1);
    check_eq("t1_wready",  64'(up_if.wready),  64'd1);
    check_eq("t1_arready", 64'(up_if.arready), 64'd1);
    tick(); at_neg();
    check_eq("t1_no_stale_aw", 64'(dn_if.awvalid), 64'd0);

    // T2 back-to-back AR stream
    dn_if.arready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick(); up_if.arvalid = 1'b1; up_if.araddr = 8'(k * 4); at_neg();
      check_eq("t2_arready", 64'(up_if.arready), 64'd1);
      if (k > 0) begin
        check_eq("t2_arvalid", 64'(dn_if.arvalid), 64'd1);
        check_eq("t2_araddr", 64'(dn_if.araddr), 64'((k - 1) * 4));
      end
    end
    tick(); up_if.arvalid = 1'b0; at_neg();
    check_eq("t2_arvalid_last", 64'(dn_if.arvalid), 64'd1);
    check_eq("t2_araddr_last", 64'(dn_if.araddr), 64'h0c);
    tick(); at_neg();
    check_eq("t2_arvalid_idle", 64'(dn_if.arvalid), 64'd0);

    // T3 skid on AW with downstream stalled
    tick(); dn_if.awready = 1'b0; up_if.awvalid = 1'b1; up_if.awaddr = 8'h10; at_neg();
    check_eq("t3_awready_c0", 64'(up_if.awready), 64'd1);
    tick(); up_if.awaddr = 8'h14; at_neg();
    check_eq("t3_awready_c1", 64'(up_if.awready), 64'd1);
    check_eq("t3_awaddr_c1", 64'(dn_if.awaddr), 64'h10);
    tick(); up_if.awvalid = 1'b0; at_neg();
    check_eq("t3_awready_full", 64'(up_if.awready), 64'd0);
    check_eq("t3_awaddr_full", 64'(dn_if.awaddr), 64'h10);
    tick(); at_neg();
    check_eq("t3_awready_full2", 64'(up_if.awready), 64'd0);
    tick(); dn_if.awready = 1'b1; at_neg();
    check_eq("t3_awaddr_rel0", 64'(dn_if.awaddr), 64'h10);
    tick(); at_neg();
    check_eq("t3_awaddr_rel1", 64'(dn_if.awaddr), 64'h14);
    check_eq("t3_awvalid_rel1", 64'(dn_if.awvalid), 64'd1);
    check_eq("t3_awready_rel1", 64'(up_if.awready), 64'd1);
    tick(); at_neg();
    check_eq("t3_awvalid_idle", 64'(dn_if.awvalid), 64'd0);

    // T4 independent AW and W, then write response
    tick(); dn_if.awready = 1'b0; dn_if.wready = 1'b0;
    up_if.awvalid = 1'b1; up_if.awaddr = 8'h20; at_neg();
    check_eq("t4_awvalid_c0", 64'(dn_if.awvalid), 64'd0);
    tick(); up_if.awvalid = 1'b0; at_neg();
    check_eq("t4_awvalid_c1", 64'(dn_if.awvalid), 64'd1);
    check_eq("t4_wvalid_c1", 64'(dn_if.wvalid), 64'd0);
    tick(); at_neg();
    tick(); up_if.wvalid = 1'b1; up_if.wdata = 32'hdeadbeef; up_if.wstrb = 4'hf; at_neg();
    check_eq("t4_wvalid_c3", 64'(dn_if.wvalid), 64'd0);
    check_eq("t4_awvalid_c3", 64'(dn_if.awvalid), 64'd1);
    tick(); up_if.wvalid = 1'b0; at_neg();
    check_eq("t4_wvalid_c4", 64'(dn_if.wvalid), 64'd1);
    check_eq("t4_wdata", 64'(dn_if.wdata), 64'hdeadbeef);
    check_eq("t4_wstrb", 64'(dn_if.wstrb), 64'hf);
    check_eq("t4_awaddr", 64'(dn_if.awaddr), 64'h20);
    tick(); dn_if.awready = 1'b1; dn_if.wready = 1'b1; at_neg();
    tick(); dn_if.awready = 1'b0; dn_if.wready = 1'b0;
    dn_if.bvalid = 1'b1; dn_if.bresp = 2'b00; up_if.bready = 1'b1; at_neg();
    check_eq("t4_aw_drained", 64'(dn_if.awvalid), 64'd0);
    check_eq("t4_w_drained", 64'(dn_if.wvalid), 64'd0);
    check_eq("t4_bready_dn", 64'(dn_if.bready), 64'd1);
    check_eq("t4_bvalid_c0", 64'(up_if.bvalid), 64'(!RESP_SLICE));
    tick(); dn_if.bvalid = 1'b0; dn_if.bresp = 2'b10; at_neg();
    check_eq("t4_bvalid_c1", 64'(up_if.bvalid), 64'(RESP_SLICE));
    tick(); up_if.bready = 1'b0; at_neg();
    check_eq("t4_bvalid_idle", 64'(up_if.bvalid), 64'd0);

    // T5 reset while AR slice is full
    tick(); dn_if.arready = 1'b0; up_if.arvalid = 1'b1; up_if.araddr = 8'h30; at_neg();
    tick(); up_if.araddr = 8'h34; at_neg();
    tick(); up_if.arvalid = 1'b0; at_neg();
    check_eq("t5_arready_full", 64'(up_if.arready), 64'd0);
    check_eq("t5_arvalid_full", 64'(dn_if.arvalid), 64'd1);
    tick(); rst_n = 1'b0; at_neg();
    tick(); rst_n = 1'b1; at_neg();
    check_eq("t5_arvalid_rst", 64'(dn_if.arvalid), 64'd0);
    check_eq("t5_arready_rst", 64'(up_if.arready), 64'd1);
    tick(); dn_if.arready = 1'b1; at_neg();
    check_eq("t5_no_stale0", 64'(dn_if.arvalid), 64'd0);
    tick(); at_neg();
    check_eq("t5_no_stale1", 64'(dn_if.arvalid), 64'd0);

    // T6 read with stalled rready
    tick(); up_if.arvalid = 1'b1; up_if.araddr = 8'h04; up_if.rready = 1'b0; at_neg();
    tick(); up_if.arvalid = 1'b0; at_neg();
    check_eq("t6_arvalid", 64'(dn_if.arvalid), 64'd1);
    check_eq("t6_araddr", 64'(dn_if.araddr), 64'h04);
    tick(); dn_if.rvalid = 1'b1; dn_if.rdata = 32'h12345678; dn_if.rresp = 2'b00; at_neg();
    check_eq("t6_rvalid_c0", 64'(up_if.rvalid), 64'(!RESP_SLICE));
    check_eq("t6_rready_dn", 64'(dn_if.rready), 64'(RESP_SLICE));
    tick(); dn_if.rvalid = !RESP_SLICE; at_neg();
    check_eq("t6_rvalid_c1", 64'(up_if.rvalid), 64'd1);
    check_eq("t6_rdata_c1", 64'(up_if.rdata), 64'h12345678);
    check_eq("t6_rresp_c1", 64'(up_if.rresp), 64'd0);
    tick(); at_neg();
    check_eq("t6_rdata_hold", 64'(up_if.rdata), 64'h12345678);
    tick(); up_if.rready = 1'b1; at_neg();
    check_eq("t6_rvalid_acc", 64'(up_if.rvalid), 64'd1);
    tick(); up_if.rready = 1'b0; dn_if.rvalid = 1'b0; at_neg();
    check_eq("t6_rvalid_idle", 64'(up_if.rvalid), 64'd0);

    // Random traffic on all request channels at once
    for (int i = 0; i < 200; i++) begin
      tick();
      up_if.awvalid = 1'($urandom_range(0, 1));
      up_if.awaddr  = 8'($urandom);
      up_if.awprot  = 3'($urandom);
      up_if.wvalid  = 1'($urandom_range(0, 1));
      up_if.wdata   = $urandom;
      up_if.wstrb   = 4'($urandom);
      up_if.arvalid = 1'($urandom_range(0, 1));
      up_if.araddr  = 8'($urandom);
      up_if.arprot  = 3'($urandom);
      dn_if.awready = ($urandom_range(0, 3) != 0);
      dn_if.wready  = ($urandom_range(0, 2) != 0);
      dn_if.arready = ($urandom_range(0, 1) != 0);
      at_neg();
    end
    tick();
    up_if.awvalid = 1'b0; up_if.wvalid = 1'b0; up_if.arvalid = 1'b0;
    dn_if.awready = 1'b1; dn_if.wready = 1'b1; dn_if.arready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      at_neg(); tick();
    end
    at_neg();
    for (int c = 0; c < 5; c++) begin
      check_eq($sformatf("drain_ch%0d", c), 64'(sbq[c].size()), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
